// File: rtl/fp_dot_acc_pkg.sv
// Shared constants, FSM state encoding and FP32 classification helpers for the dot-product accumulator.
package fp_dot_acc_pkg;

  localparam int          FP_WIDTH    = 32;
  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;

  // State encoding: {ACCUM, DRAIN, REDUCE, DONE}
  localparam logic [1:0] ST_ACCUM  = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_REDUCE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  function automatic logic fp_is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  function automatic logic fp_is_inf(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
  endfunction

endpackage

// File: rtl/fp_add_pipe.sv
// LATENCY-deep pipelined IEEE-754 single-precision adder, round-to-nearest-even, subnormal aware.
// The sum is formed in front of the first register and then carried through LATENCY stages.
module fp_add_pipe import fp_dot_acc_pkg::*; #(
  parameter int LATENCY = 4
) (
  input  logic                clkIn,
  input  logic                rstIn,
  input  logic [FP_WIDTH-1:0] dataAIn,
  input  logic [FP_WIDTH-1:0] dataBIn,
  output logic [FP_WIDTH-1:0] dataOut
);

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, res;
    logic [8:0]  ex, ey, e, d;
    logic [23:0] mx, my;
    logic [26:0] ax, ay, mask;
    logic [27:0] s;
    logic [24:0] rnd;
    logic        sub, inc, sticky;
    res = FP_POS_ZERO;
    if (fp_is_nan(a)) res = a | 32'h0040_0000;
    else if (fp_is_nan(b)) res = b | 32'h0040_0000;
    else if (fp_is_inf(a) && fp_is_inf(b) && (a[31] != b[31])) res = FP_QNAN;
    else if (fp_is_inf(a)) res = a;
    else if (fp_is_inf(b)) res = b;
    else begin
      if (a[30:0] >= b[30:0]) begin x = a; y = b; end
      else begin x = b; y = a; end
      ex = (x[30:23] == 8'd0) ? 9'd1 : {1'b0, x[30:23]};
      ey = (y[30:23] == 8'd0) ? 9'd1 : {1'b0, y[30:23]};
      mx = {x[30:23] != 8'd0, x[22:0]};
      my = {y[30:23] != 8'd0, y[22:0]};
      d  = ex - ey;
      ax = {mx, 3'b000};
      ay = {my, 3'b000};
      // Guard/round/sticky live in the three low bits of the aligned operand
      if (d >= 9'd27) ay = {26'd0, |my};
      else begin
        mask   = (27'd1 << d) - 27'd1;
        sticky = |(ay & mask);
        ay     = (ay >> d) | {26'd0, sticky};
      end
      sub = x[31] ^ y[31];
      e   = ex;
      s   = sub ? ({1'b0, ax} - {1'b0, ay}) : ({1'b0, ax} + {1'b0, ay});
      if (s == 28'd0) res = sub ? FP_POS_ZERO : {x[31], 31'd0};
      else begin
        if (s[27]) begin
          s = {1'b0, s[27:2], s[1] | s[0]};
          e = e + 9'd1;
        end
        for (int i = 0; i < 26; i++) begin
          if (!s[26] && (e > 9'd1)) begin
            s = s << 1;
            e = e - 9'd1;
          end
        end
        inc = s[2] & (s[1] | s[0] | s[3]);
        rnd = {1'b0, s[26:3]} + {24'd0, inc};
        if (rnd[24]) begin
          rnd = 25'h080_0000;
          e   = e + 9'd1;
        end
        if (e >= 9'd255) res = {x[31], 8'hFF, 23'd0};
        else res = {x[31], (rnd[23] ? e[7:0] : 8'd0), rnd[22:0]};
      end
    end
    return res;
  endfunction

  logic [FP_WIDTH-1:0] pipe [LATENCY];

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= FP_POS_ZERO;
    end else begin
      pipe[0] <= fp_add(dataAIn, dataBIn);
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dataOut = pipe[LATENCY-1];

endmodule

// File: rtl/fp_dot_product_accumulator.sv
// FP32 dot-product accumulator: L interleaved partial sums circulate through an L-deep adder, then get folded.
// Optional result flags nanOut/infOut are built when FP_DOT_ACC_FLAGS_EN is defined.
module fp_dot_product_accumulator import fp_dot_acc_pkg::*; #(
  parameter int ADD_LATENCY = 4,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                 clkIn,
  input  logic                 rstIn,
  input  logic [FP_WIDTH-1:0]  dataIn,
  input  logic                 validIn,
  input  logic                 lastIn,
  output logic                 readyOut,
  output logic [FP_WIDTH-1:0]  dataOut,
  output logic                 validOut,
  output logic [LEN_WIDTH-1:0] countOut,
`ifdef FP_DOT_ACC_FLAGS_EN
  output logic                 nanOut,
  output logic                 infOut,
`endif
  output logic [1:0]           fsm_state
);

  localparam int IDX_W = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ADD_LATENCY - 1);

  logic [1:0]           state;
  logic [IDX_W-1:0]     drain_idx, red_idx, wait_cnt;
  logic [LEN_WIDTH-1:0] count, count_q;
  logic [FP_WIDTH-1:0]  data_q;
  logic [FP_WIDTH-1:0]  lane [ADD_LATENCY];
  logic [FP_WIDTH-1:0]  add_a, add_b, add_out;
  logic                 accept;

  // Handshake: a product transfers on a rising edge where validIn && readyOut; lastIn is only
  // meaningful on that transfer. validIn while readyOut=0 is dropped, upstream must hold or retry.
  assign accept   = validIn && (state == ST_ACCUM);
  assign readyOut = (state == ST_ACCUM);
  assign validOut = (state == ST_DONE);
  assign fsm_state = state;

  // The final reduce sum emerges from the adder during DONE, so it is presented directly then held.
  assign dataOut  = validOut ? add_out : data_q;
  assign countOut = validOut ? count : count_q;

  fp_add_pipe #(.LATENCY(ADD_LATENCY)) u_add (
    .clkIn   (clkIn),
    .rstIn   (rstIn),
    .dataAIn (add_a),
    .dataBIn (add_b),
    .dataOut (add_out)
  );

  // Any cycle not explicitly issuing feeds +0+0, which flushes the pipe to +0.0 by the end of DONE.
  always_comb begin
    add_a = FP_POS_ZERO;
    add_b = FP_POS_ZERO;
    case (state)
      ST_ACCUM: begin
        add_a = accept ? dataIn : FP_POS_ZERO;
        add_b = add_out;
      end
      ST_DRAIN: add_b = add_out;
      ST_REDUCE: begin
        if (wait_cnt == '0) begin
          add_a = (red_idx == IDX_W'(1)) ? lane[0] : add_out;
          add_b = lane[red_idx];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      state     <= ST_ACCUM;
      drain_idx <= '0;
      red_idx   <= '0;
      wait_cnt  <= '0;
      count     <= '0;
      count_q   <= '0;
      data_q    <= FP_POS_ZERO;
      for (int i = 0; i < ADD_LATENCY; i++) lane[i] <= FP_POS_ZERO;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            count <= count + 1'b1;
            if (lastIn) begin
              state     <= ST_DRAIN;
              drain_idx <= '0;
            end
          end
        end
        ST_DRAIN: begin
          lane[drain_idx] <= add_out;
          if (drain_idx == LAST_IDX) begin
            state    <= (ADD_LATENCY == 1) ? ST_DONE : ST_REDUCE;
            red_idx  <= IDX_W'(1);
            wait_cnt <= '0;
          end else begin
            drain_idx <= drain_idx + 1'b1;
          end
        end
        ST_REDUCE: begin
          if (wait_cnt == LAST_IDX) begin
            wait_cnt <= '0;
            if (red_idx == LAST_IDX) state <= ST_DONE;
            else red_idx <= red_idx + 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          data_q  <= add_out;
          count_q <= count;
          count   <= '0;
          state   <= ST_ACCUM;
        end
      endcase
    end
  end

`ifdef FP_DOT_ACC_FLAGS_EN
  logic nan_q, inf_q;

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      nan_q <= 1'b0;
      inf_q <= 1'b0;
    end else if (state == ST_DONE) begin
      nan_q <= fp_is_nan(add_out);
      inf_q <= fp_is_inf(add_out);
    end
  end

  assign nanOut = validOut ? fp_is_nan(add_out) : nan_q;
  assign infOut = validOut ? fp_is_inf(add_out) : inf_q;
`endif

endmodule

// File: tb/tb_fp_dot_product_accumulator.sv
// Self-checking bench for fp_dot_product_accumulator (L=4, 4-bit product counter to exercise wrap).
module tb_fp_dot_product_accumulator;

  localparam int L   = 4;
  localparam int LW  = 4;
  localparam int LAT = L * L + 1;

  logic          clkIn = 1'b0;
  logic          rstIn = 1'b0;
  logic [31:0]   dataIn = 32'd0;
  logic          validIn = 1'b0;
  logic          lastIn = 1'b0;
  logic          readyOut;
  logic [31:0]   dataOut;
  logic          validOut;
  logic [LW-1:0] countOut;
  logic [1:0]    fsm_state;
`ifdef FP_DOT_ACC_FLAGS_EN
  logic          nanOut, infOut;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  int          cnt_q[$];
  int          lat_q[$];
  logic [31:0] vec[$];
  logic        prev_valid = 1'b0;
  logic        exp_ready;

  fp_dot_product_accumulator #(.ADD_LATENCY(L), .LEN_WIDTH(LW)) dut (
    .clkIn     (clkIn),
    .rstIn     (rstIn),
    .dataIn    (dataIn),
    .validIn   (validIn),
    .lastIn    (lastIn),
    .readyOut  (readyOut),
    .dataOut   (dataOut),
    .validOut  (validOut),
    .countOut  (countOut),
`ifdef FP_DOT_ACC_FLAGS_EN
    .nanOut    (nanOut),
    .infOut    (infOut),
`endif
    .fsm_state (fsm_state)
  );

  // clock / reset
  always #5 clkIn = ~clkIn;
  always @(posedge clkIn) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
  endfunction

  function automatic logic [31:0] canon(input logic [31:0] v);
    return is_nan(v) ? 32'h7FC0_0000 : v;
  endfunction

  // Exact FP32 encoding of v/8 for |v| < 2^24
  function automatic logic [31:0] to_fp(input int v);
    logic [31:0] mag, man, r;
    int p;
    r = 32'd0;
    if (v != 0) begin
      mag = (v < 0) ? 32'(-v) : 32'(v);
      p = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) p = i;
      man = (p <= 23) ? (mag << (23 - p)) : (mag >> (p - 23));
      r = {v < 0, 8'(p + 124), man[22:0]};
    end
    return r;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!readyOut && n < 100) begin
      tick();
      n++;
    end
    check("ready_wait", 32'(readyOut), 32'd1);
  endtask

  task automatic push_exp(input logic [31:0] e, input int n);
    exp_q.push_back(e);
    cnt_q.push_back(n % (1 << LW));
  endtask

  task automatic send_vector(input int gap_lo, input int gap_hi, input bit with_last, input bit hold_busy);
    int gap, n;
    wait_ready();
    for (int i = 0; i < vec.size(); i++) begin
      dataIn  = vec[i];
      validIn = 1'b1;
      lastIn  = with_last && (i == vec.size() - 1);
      if (lastIn) lat_q.push_back(cyc);
      tick();
      validIn = 1'b0;
      lastIn  = 1'b0;
      if (i != vec.size() - 1) begin
        gap = $urandom_range(gap_hi, gap_lo);
        for (int g = 0; g < gap; g++) begin
          dataIn = $urandom();
          lastIn = 1'($urandom_range(1, 0));
          tick();
        end
        lastIn = 1'b0;
      end
    end
    if (hold_busy) begin
      dataIn  = 32'h42C8_0000;
      validIn = 1'b1;
      n = 0;
      while (!validOut && n < 60) begin
        tick();
        n++;
      end
    end
    validIn = 1'b0;
    lastIn  = 1'b0;
  endtask

  // scoreboard
  always @(negedge clkIn) begin
    if (rstIn) begin
      exp_ready = !(lat_q.size() != 0 && cyc > lat_q[0]);
      check("ready", 32'(readyOut), 32'(exp_ready));
      if (validOut) begin
        check("valid_pulse", 32'(prev_valid), 32'd0);
        if (exp_q.size() == 0 || lat_q.size() == 0) begin
          check("unexpected_valid", 32'(validOut), 32'd0);
        end else begin
          logic [31:0] e;
          int c, t;
          e = exp_q.pop_front();
          c = cnt_q.pop_front();
          t = lat_q.pop_front();
          check("data", canon(dataOut), canon(e));
          check("count", 32'(countOut), 32'(c));
          check("latency", 32'(cyc - t), 32'(LAT));
`ifdef FP_DOT_ACC_FLAGS_EN
          check("nan_flag", 32'(nanOut), 32'(is_nan(e)));
          check("inf_flag", 32'(infOut), 32'(is_inf(e)));
`endif
        end
      end else if (lat_q.size() != 0 && cyc > lat_q[0] + LAT + 10) begin
        check("valid_timeout", 32'(validOut), 32'd1);
        void'(lat_q.pop_front());
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (cnt_q.size() != 0) void'(cnt_q.pop_front());
      end
      prev_valid = validOut;
    end
  end

  logic [31:0] dir_a [7];
  logic [31:0] dir_b [7];
  logic [31:0] dir_e [7];

  initial begin
    int n, sum, k, w;
    dir_a = '{32'h3F80_0001, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0001,
              32'h3F80_0000, 32'h7F7F_FFFF, 32'h7F80_0000};
    dir_b = '{32'h3380_0000, 32'h3380_0000, 32'h3380_0001, 32'h0000_0001,
              32'hBF80_0000, 32'h7F7F_FFFF, 32'hFF80_0000};
    dir_e = '{32'h3F80_0002, 32'h3F80_0000, 32'h3F80_0001, 32'h0000_0002,
              32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000};

    repeat (2) @(posedge clkIn);
    #1;
    check("rst_data", dataOut, 32'd0);
    check("rst_valid", 32'(validOut), 32'd0);
    check("rst_count", 32'(countOut), 32'd0);
    rstIn = 1'b1;
    tick();

    vec = '{32'h3F80_0000};
    push_exp(32'h3F80_0000, 1);
    send_vector(0, 0, 1'b1, 1'b0);

    vec.delete();
    repeat (8) vec.push_back(32'h4000_0000);
    push_exp(32'h4180_0000, 8);
    send_vector(0, 0, 1'b1, 1'b0);

    vec = '{32'h3FC0_0000, 32'h3FC0_0000, 32'h3FC0_0000};
    push_exp(32'h4090_0000, 3);
    send_vector(2, 2, 1'b1, 1'b0);

    // Busy-time traffic of 100.0 must not leak into either vector
    vec = '{32'h3F80_0000, 32'h3F80_0000};
    push_exp(32'h4000_0000, 2);
    send_vector(0, 1, 1'b1, 1'b1);
    vec = '{32'h4040_0000};
    push_exp(32'h4040_0000, 1);
    send_vector(0, 0, 1'b1, 1'b0);

    // Reset in the middle of a vector discards it
    vec = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
    send_vector(0, 1, 1'b0, 1'b0);
    rstIn = 1'b0;
    #1;
    check("midrst_data", dataOut, 32'd0);
    check("midrst_valid", 32'(validOut), 32'd0);
    check("midrst_count", 32'(countOut), 32'd0);
    tick();
    tick();
    rstIn = 1'b1;
    tick();
    vec = '{32'h4040_0000};
    push_exp(32'h4040_0000, 1);
    send_vector(0, 0, 1'b1, 1'b0);

    vec = '{32'h8000_0000};
    push_exp(32'h0000_0000, 1);
    send_vector(0, 0, 1'b1, 1'b0);

    for (int i = 0; i < 7; i++) begin
      vec = '{dir_a[i], dir_b[i]};
      push_exp(dir_e[i], 2);
      send_vector(0, 2, 1'b1, 1'b0);
    end
    vec = '{32'h7F80_0000};
    push_exp(32'h7F80_0000, 1);
    send_vector(0, 0, 1'b1, 1'b0);

    // Random vectors: multiples of 1/8 small enough that every partial sum is exact
    for (int r = 0; r < 14; r++) begin
      n = $urandom_range(20, 1);
      sum = 0;
      vec.delete();
      for (int i = 0; i < n; i++) begin
        k = int'($urandom_range(8000, 0)) - 4000;
        if ($urandom_range(9, 0) == 0) k = 0;
        sum += k;
        vec.push_back(to_fp(k));
      end
      push_exp(to_fp(sum), n);
      send_vector(0, 3, 1'b1, 1'b0);
    end

    w = 0;
    while (lat_q.size() != 0 && w < 100) begin
      tick();
      w++;
    end
    tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
